mul_share_ctrl: RTL

- Sequencer and arbiter that shares the single iterative 32x32 multiplier between two requesters (e.g. ALU issue port and address-generation unit).
- Accepts operand requests over valid/ready, arbitrates round-robin, and launches one multiply at a time.
- Holds multiplier inputs stable for the whole operation and waits for completion or a timeout.
- Returns the 64-bit product to the winning requester over valid/ready.

---
 rtl/mul_share_ctrl_if.sv | 53 +++++
 rtl/mul_share_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl_if.sv
// Bundle of requester, response and multiplier-side signals around the shared
// multiplier controller; slave is the controller, master is everything around it.
interface mul_share_ctrl_if;
    // Every valid/ready pair transfers on a cycle where both are high; a source
    // holds its payload stable while valid is high and ready is low.
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [4:0]  req0_ctrl;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [4:0]  req1_ctrl;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [4:0]  mul_ctrl;
    logic        mul_start;
    logic        mul_done;
    logic [31:0] mul_lo;
    logic [31:0] mul_hi;
    logic [1:0]  dbg_state;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  rsp0_ready, rsp1_ready,
        input  mul_done, mul_lo, mul_hi,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_lo, rsp_hi, rsp_err,
        output mul_a, mul_b, mul_ctrl, mul_start,
        output dbg_state
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output rsp0_ready, rsp1_ready,
        output mul_done, mul_lo, mul_hi,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_lo, rsp_hi, rsp_err,
        input  mul_a, mul_b, mul_ctrl, mul_start,
        input  dbg_state
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer sharing one iterative 32x32 multiplier between two
// requesters, with a per-operation timeout and a shared result bus.
module mul_share_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_share_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [4:0]    op_ctrl_q, op_ctrl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_lo_q, res_lo_d;
    logic [31:0]   res_hi_q, res_hi_d;
    logic          err_q, err_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic          mul_start_q, mul_start_d;
    logic          mul_en_q, mul_en_d;

    logic take0;
    logic take1;
    logic rsp_ready_sel;

    // On contention the requester that did not win last time goes first.
    assign take0         = bus.req0_valid & (~bus.req1_valid | last_q);
    assign take1         = bus.req1_valid & (~bus.req0_valid | ~last_q);
    assign rsp_ready_sel = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_ctrl_d   = op_ctrl_q;
        cnt_d       = cnt_q;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        mul_start_d = mul_start_q;
        mul_en_d    = mul_en_q;

        case (state_q)
            S_IDLE: begin
                if (take0 | take1) begin
                    gnt_d       = take1;
                    last_d      = take1;
                    op_a_d      = take1 ? bus.req1_a    : bus.req0_a;
                    op_b_d      = take1 ? bus.req1_b    : bus.req0_b;
                    op_ctrl_d   = take1 ? bus.req1_ctrl : bus.req0_ctrl;
                    mul_start_d = 1'b1;
                    mul_en_d    = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start_d = 1'b0;
                cnt_d       = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A completion on the final allowed cycle still beats the timeout.
                if (bus.mul_done) begin
                    res_lo_d    = bus.mul_lo;
                    res_hi_d    = bus.mul_hi;
                    err_d       = 1'b0;
                    rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                    mul_en_d    = 1'b0;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    res_lo_d    = '0;
                    res_hi_d    = '0;
                    err_d       = 1'b1;
                    rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                    mul_en_d    = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_sel) begin
                    rsp_valid_d = 2'b00;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_ctrl_q   <= '0;
            cnt_q       <= '0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
            mul_start_q <= 1'b0;
            mul_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_ctrl_q   <= op_ctrl_d;
            cnt_q       <= cnt_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            mul_start_q <= mul_start_d;
            mul_en_q    <= mul_en_d;
        end
    end

    // Ready is the only combinational output; it is gated so reset forces it low.
    assign bus.req0_ready = rst_n & (state_q == S_IDLE) & take0;
    assign bus.req1_ready = rst_n & (state_q == S_IDLE) & take1;
    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp_lo     = res_lo_q;
    assign bus.rsp_hi     = res_hi_q;
    assign bus.rsp_err    = err_q;
    assign bus.mul_a      = mul_en_q ? op_a_q    : '0;
    assign bus.mul_b      = mul_en_q ? op_b_q    : '0;
    assign bus.mul_ctrl   = mul_en_q ? op_ctrl_q : '0;
    assign bus.mul_start  = mul_start_q;
    assign bus.dbg_state  = state_q;

endmodule
